stopwatch_core: RTL

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/stopwatch_bcd_digit_cnt.sv | 41 ++++
 rtl/stopwatch_core.sv | 116 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
// State encoding and BCD digit terminal counts.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int BCD_W   = 4;
  localparam int DIG_TC9 = 9;
  localparam int DIG_TC5 = 5;

endpackage

// File: rtl/stopwatch_bcd_digit_cnt.sv
// Single modulo-(TC+1) BCD digit with increment, clear and carry.
// o_next exposes the value the digit takes on the coming edge.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int TC = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [BCD_W-1:0] o_q,
  output logic [BCD_W-1:0] o_next,
  output logic             o_carry
);

  localparam logic [BCD_W-1:0] L_TC = BCD_W'(TC);

  logic [BCD_W-1:0] r_q;

  assign o_q     = r_q;
  assign o_carry = i_inc && (r_q == L_TC);

  always_comb begin
    o_next = r_q;
    if (i_clr) begin
      o_next = '0;
    end else if (i_inc) begin
      o_next = o_carry ? '0 : r_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= o_next;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: IDLE/RUN/PAUSE control, six-digit BCD count,
// lap freeze snapshot and sticky overflow.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN_TENS = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  state_t r_state;
  state_t w_nstate;

  logic        r_lap;
  logic        r_ovf;
  logic [23:0] r_snap;
  logic [23:0] r_disp;

  logic        w_inc;
  logic        w_clr;
  logic        w_lap_nx;
  logic        w_ovf_nx;
  logic [23:0] w_snap_nx;
  logic [23:0] w_cnt_nx;

  logic [BCD_W-1:0] w_q  [6];
  logic [BCD_W-1:0] w_nx [6];
  logic             w_cy [6];
  logic             w_en [6];

  assign w_inc = tick && (r_state == RUN);
  assign w_clr = clear && (r_state != RUN);

  // Index 0 is cs_ones, index 5 is m_tens.
  for (genvar i = 0; i < 6; i++) begin : g_dig
    localparam int L_TC = (i == 5) ? MAX_MIN_TENS :
                          (i == 3) ? DIG_TC5 : DIG_TC9;
    if (i == 0) begin : g_lsd
      assign w_en[i] = w_inc;
    end else begin : g_up
      assign w_en[i] = w_cy[i-1];
    end
    bcd_digit_cnt #(.TC(L_TC)) u_dig (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_inc   (w_en[i]),
      .i_clr   (w_clr),
      .o_q     (w_q[i]),
      .o_next  (w_nx[i]),
      .o_carry (w_cy[i])
    );
  end

  assign w_cnt_nx = {w_nx[5], w_nx[4], w_nx[3],
                     w_nx[2], w_nx[1], w_nx[0]};

  always_comb begin
    w_nstate  = r_state;
    w_lap_nx  = r_lap;
    w_ovf_nx  = r_ovf;
    w_snap_nx = r_snap;
    unique case (r_state)
      IDLE: begin
        if (!clear && start_stop) w_nstate = RUN;
      end
      RUN: begin
        if (start_stop) w_nstate = PAUSE;
      end
      PAUSE: begin
        if (clear) w_nstate = IDLE;
        else if (start_stop) w_nstate = RUN;
      end
      default: w_nstate = IDLE;
    endcase
    if (r_state == RUN) begin
      if (lap) w_lap_nx = !r_lap;
    end else if (lap || clear) begin
      w_lap_nx = 1'b0;
    end
    if (w_clr) w_ovf_nx = 1'b0;
    else if (w_cy[5]) w_ovf_nx = 1'b1;
    // Snapshot takes the post-increment value of this cycle.
    if (r_state == RUN && lap && !r_lap) w_snap_nx = w_cnt_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lap   <= 1'b0;
      r_ovf   <= 1'b0;
      r_snap  <= '0;
      r_disp  <= '0;
    end else begin
      r_state <= w_nstate;
      r_lap   <= w_lap_nx;
      r_ovf   <= w_ovf_nx;
      r_snap  <= w_snap_nx;
      r_disp  <= w_lap_nx ? w_snap_nx : w_cnt_nx;
    end
  end

  assign disp_bcd   = r_disp;
  assign running    = (r_state == RUN);
  assign lap_active = r_lap;
  assign overflow   = r_ovf;

endmodule
